// File: rtl/denoise_hog_core.sv
// Streaming 3x3 median-of-medians denoise followed by gradient magnitude.
// One 5x14 pixel window in per clock, one 3x12 block of 12-bit magnitudes out per clock.
module denoise_hog_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [559:0] pixel_in,
    output logic         valid,
    output logic [7:0]   cnt_row,
    output logic [5:0]   cnt_col,
    output logic [107:0] block_out_0,
    output logic [107:0] block_out_1,
    output logic [107:0] block_out_2,
    output logic [107:0] block_out_3
);

    localparam int unsigned BANDS = 160;
    localparam int unsigned WINS  = 53;
    localparam int unsigned PW    = 8;
    localparam int unsigned MW    = 12;
    localparam int unsigned SQW   = 16;
    localparam int unsigned SW    = 17;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;
    logic   samp_c;

    logic [7:0]                  band_q, band_d;
    logic [5:0]                  win_q, win_d;
    logic [4:0][13:0][PW-1:0]    pix_q, pix_d;
    logic                        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [7:0]                  b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic [5:0]                  k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [2:0][11:0][PW-1:0]    d_q, d_d;
    logic [WINS-1:0][1:0][11:0][PW-1:0] lb_q, lb_d;
    logic [4:0][1:0][PW-1:0]     pc_q, pc_d;
    logic [4:0][13:0][PW-1:0]    e_c;
    logic [2:0][11:0][SW-1:0]    sq_q, sq_d;
    logic                        valid_q, valid_d;
    logic [7:0]                  cnt_row_q, cnt_row_d;
    logic [5:0]                  cnt_col_q, cnt_col_d;
    logic [3:0][8:0][MW-1:0]     blk_q, blk_d;

    function automatic logic [PW-1:0] med3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
        logic [PW-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c <= lo)      return lo;
        else if (c >= hi) return hi;
        else              return c;
    endfunction

    function automatic logic [SQW-1:0] sqr_diff(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] ad;
        ad = (a > b) ? a - b : b - a;
        return SQW'(ad) * SQW'(ad);
    endfunction

    // Bitwise restoring square root; 17-bit operand gives at most 9 result bits.
    function automatic logic [MW-1:0] isqrt(input logic [SW-1:0] v);
        logic [8:0] r, t;
        r = '0;
        for (int i = 8; i >= 0; i--) begin
            t = r | (9'd1 << i);
            if (18'(t) * 18'(t) <= 18'(v)) r = t;
        end
        return MW'(r);
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   if (band_q == 8'(BANDS - 1) && win_q == 6'(WINS - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        samp_c = 1'b0;
        if (state_q == S_RUN) samp_c = 1'b1;
    end

    // Window position counters and input capture.
    always_comb begin
        band_d = band_q;
        win_d  = win_q;
        if (samp_c) begin
            if (win_q == 6'(WINS - 1)) begin
                win_d  = '0;
                band_d = band_q + 8'd1;
            end else begin
                win_d = win_q + 6'd1;
            end
        end
        pix_d = pixel_in;
        v1_d  = samp_c;
        b1_d  = band_q;
        k1_d  = win_q;
    end

    // Denoise: d_d[i][j] is D(3b+i, 635-12k-j); pixel column c of a row sits at index 13-c.
    always_comb begin
        d_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 12; j++) begin
                d_d[i][j] = med3(med3(pix_q[4-i][13-j], pix_q[4-i][12-j], pix_q[4-i][11-j]),
                                 med3(pix_q[3-i][13-j], pix_q[3-i][12-j], pix_q[3-i][11-j]),
                                 med3(pix_q[2-i][13-j], pix_q[2-i][12-j], pix_q[2-i][11-j]));
            end
        end
        v2_d = v1_q;
        b2_d = b1_q;
        k2_d = k1_q;
    end

    // 5x14 neighbourhood: rows 3b-2..3b+2, cols 637-12k down to 624-12k.
    always_comb begin
        e_c = '0;
        for (int rr = 0; rr < 5; rr++) begin
            for (int jj = 0; jj < 14; jj++) begin
                if (jj < 2)      e_c[rr][jj] = pc_q[rr][jj];
                else if (rr < 2) e_c[rr][jj] = lb_q[k2_q][rr][jj-2];
                else             e_c[rr][jj] = d_q[rr-2][jj-2];
            end
        end
    end

    always_comb begin
        lb_d = lb_q;
        pc_d = pc_q;
        if (v2_q) begin
            lb_d[k2_q][0] = d_q[1];
            lb_d[k2_q][1] = d_q[2];
            for (int rr = 0; rr < 5; rr++) begin
                pc_d[rr][0] = e_c[rr][12];
                pc_d[rr][1] = e_c[rr][13];
            end
        end
        sq_d = '0;
        for (int ri = 0; ri < 3; ri++) begin
            for (int m = 0; m < 12; m++) begin
                sq_d[ri][m] = SW'(sqr_diff(e_c[ri+1][m+2], e_c[ri+1][m]))
                            + SW'(sqr_diff(e_c[ri][m+1], e_c[ri+2][m+1]));
            end
        end
        v3_d = v2_q;
        b3_d = b2_q;
        k3_d = k2_q;
    end

    // Output stage: square root, border zeroing and sub-block packing.
    always_comb begin
        valid_d   = v3_q;
        cnt_row_d = cnt_row_q;
        cnt_col_d = cnt_col_q;
        blk_d     = blk_q;
        if (v3_q) begin
            cnt_row_d = b3_q;
            cnt_col_d = k3_q;
            for (int j = 0; j < 4; j++) begin
                for (int ri = 0; ri < 3; ri++) begin
                    for (int ci = 0; ci < 3; ci++) begin
                        if ((b3_q == 8'd0 && ri < 2) || (k3_q == 6'd0 && (3*j + ci) < 2))
                            blk_d[j][8-(3*ri+ci)] = '0;
                        else
                            blk_d[j][8-(3*ri+ci)] = isqrt(sq_q[ri][3*j+ci]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            band_q    <= '0;
            win_q     <= '0;
            pix_q     <= '0;
            v1_q      <= 1'b0;
            b1_q      <= '0;
            k1_q      <= '0;
            d_q       <= '0;
            v2_q      <= 1'b0;
            b2_q      <= '0;
            k2_q      <= '0;
            lb_q      <= '0;
            pc_q      <= '0;
            sq_q      <= '0;
            v3_q      <= 1'b0;
            b3_q      <= '0;
            k3_q      <= '0;
            valid_q   <= 1'b0;
            cnt_row_q <= '0;
            cnt_col_q <= '0;
            blk_q     <= '0;
        end else begin
            band_q    <= band_d;
            win_q     <= win_d;
            pix_q     <= pix_d;
            v1_q      <= v1_d;
            b1_q      <= b1_d;
            k1_q      <= k1_d;
            d_q       <= d_d;
            v2_q      <= v2_d;
            b2_q      <= b2_d;
            k2_q      <= k2_d;
            lb_q      <= lb_d;
            pc_q      <= pc_d;
            sq_q      <= sq_d;
            v3_q      <= v3_d;
            b3_q      <= b3_d;
            k3_q      <= k3_d;
            valid_q   <= valid_d;
            cnt_row_q <= cnt_row_d;
            cnt_col_q <= cnt_col_d;
            blk_q     <= blk_d;
        end
    end

    assign valid       = valid_q;
    assign cnt_row     = cnt_row_q;
    assign cnt_col     = cnt_col_q;
    assign block_out_0 = blk_q[0];
    assign block_out_1 = blk_q[1];
    assign block_out_2 = blk_q[2];
    assign block_out_3 = blk_q[3];

endmodule

// File: tb/tb_denoise_hog_core.sv
// Bench for denoise_hog_core: whole-image reference (denoised image, magnitude map)
// compared against every output block for several test images, plus a mid-stream reset.
module tb_denoise_hog_core;

    localparam int NWIN = 8480;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [559:0] pixel_in;
    logic         valid;
    logic [7:0]   cnt_row;
    logic [5:0]   cnt_col;
    logic [107:0] block_out_0, block_out_1, block_out_2, block_out_3;

    byte unsigned img  [482][638];
    byte unsigned dref [480][636];
    int           mdut [480][637];
    int           checks = 0;
    int           errors = 0;
    int           nvalid;

    always #5 clk = ~clk;

    denoise_hog_core dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid(valid),
        .cnt_row(cnt_row), .cnt_col(cnt_col),
        .block_out_0(block_out_0), .block_out_1(block_out_1),
        .block_out_2(block_out_2), .block_out_3(block_out_3)
    );

    task automatic check(input string tag, input int idx, input logic [127:0] obs,
                         input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s idx=%0d observed=%0h expected=%0h", tag, idx, obs, exp_v);
        end
    endtask

    function automatic int med3(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;  mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b;  mn = (mn < c) ? mn : c;
        return a + b + c - mx - mn;
    endfunction

    task automatic fill(input int mode);
        for (int r = 0; r < 482; r++)
            for (int c = 0; c < 638; c++)
                case (mode)
                    0: img[r][c] = 8'd100;
                    1: img[r][c] = (r % 7 == 3 && c % 9 == 4) ? 8'd255 : 8'd50;
                    2: img[r][c] = (c < 320) ? 8'd0 : 8'd200;
                    3: img[r][c] = (r < 300) ? 8'd0 : 8'd80;
                    default: img[r][c] = 8'($urandom_range(0, 255));
                endcase
        for (int r = 0; r < 480; r++)
            for (int d = 0; d < 636; d++)
                dref[r][d] = 8'(med3(med3(img[r][d],   img[r][d+1],   img[r][d+2]),
                                     med3(img[r+1][d], img[r+1][d+1], img[r+1][d+2]),
                                     med3(img[r+2][d], img[r+2][d+1], img[r+2][d+2])));
    endtask

    function automatic int exp_m(input int r, input int c);
        int gx, gy, s, m;
        if (r <= 0 || c >= 635) return 0;
        gx = int'(dref[r][c-1]) - int'(dref[r][c+1]);
        gy = int'(dref[r-1][c]) - int'(dref[r+1][c]);
        s  = gx * gx + gy * gy;
        m  = int'($sqrt(real'(s)));
        while (m * m > s) m--;
        while ((m + 1) * (m + 1) <= s) m++;
        return m;
    endfunction

    function automatic logic [559:0] window(input int n);
        logic [559:0] w;
        int b, s;
        b = n / 53;
        s = 637 - 12 * (n % 53);
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 14; c++)
                w[559 - 112*r - 8*c -: 8] = img[3*b + r][s - c];
        return w;
    endfunction

    function automatic logic [107:0] exp_block(input int n, input int j);
        logic [107:0] v;
        int b, k;
        b = n / 53;
        k = n % 53;
        v = '0;
        for (int ri = 0; ri < 3; ri++)
            for (int ci = 0; ci < 3; ci++)
                v[107 - 12*(3*ri + ci) -: 12] = 12'(exp_m(3*b - 1 + ri, 636 - 12*k - 3*j - ci));
        return v;
    endfunction

    // Reset must be asserted on entry; it is released at the first negedge (t=0).
    task automatic run_frame(input int abort_at);
        logic [107:0] bo [4];
        int n, b, k;
        nvalid = 0;
        for (int r = 0; r < 480; r++)
            for (int c = 0; c < 637; c++)
                mdut[r][c] = -1;
        for (int t = 0; t <= NWIN + 7; t++) begin
            @(negedge clk);
            if (t == abort_at) return;
            bo[0] = block_out_0; bo[1] = block_out_1;
            bo[2] = block_out_2; bo[3] = block_out_3;
            if (t == 0) begin
                check("rst_valid", t, valid, 0);
                check("rst_cnt", t, {cnt_row, cnt_col}, 0);
                for (int j = 0; j < 4; j++) check("rst_block", j, bo[j], 0);
                rst_n = 1'b0;
            end else begin
                n = t - 5;
                if (valid === 1'b1) nvalid++;
                if (n >= 0 && n < NWIN) begin
                    b = n / 53;
                    k = n % 53;
                    check("valid_hi", n, valid, 1);
                    check("cnt_row", n, cnt_row, b);
                    check("cnt_col", n, cnt_col, k);
                    for (int j = 0; j < 4; j++) begin
                        check("block", n * 4 + j, bo[j], exp_block(n, j));
                        for (int ri = 0; ri < 3; ri++)
                            for (int ci = 0; ci < 3; ci++)
                                mdut[3*b + ri][636 - 12*k - 3*j - ci] =
                                    int'(bo[j][107 - 12*(3*ri + ci) -: 12]);
                    end
                end else begin
                    check("valid_lo", t, valid, 0);
                end
            end
            pixel_in = (t >= 1 && t <= NWIN) ? window(t - 1) : '0;
        end
        check("valid_cycles", 0, nvalid, NWIN);
    endtask

    task automatic reset_on();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    function automatic int count_nonzero();
        int nz = 0;
        for (int r = 0; r < 480; r++)
            for (int c = 1; c < 637; c++)
                if (mdut[r][c] != 0) nz++;
        return nz;
    endfunction

    initial begin
        rst_n    = 1'b1;
        pixel_in = '0;
        repeat (3) @(negedge clk);

        // Flat image
        fill(0);
        run_frame(-1);
        check("flat_nonzero", 0, count_nonzero(), 0);

        // Flat 50 with isolated impulses
        reset_on();
        fill(1);
        run_frame(-1);
        check("impulse_nonzero", 0, count_nonzero(), 0);

        // Vertical step at input col 320
        reset_on();
        fill(2);
        run_frame(-1);
        check("vstep_318", 0, mdut[101][318], 200);
        check("vstep_319", 0, mdut[101][319], 200);
        check("vstep_317", 0, mdut[101][317], 0);
        check("vstep_320", 0, mdut[101][320], 0);

        // Horizontal step at input row 300, magnitude rows 298/299 straddle a band boundary
        reset_on();
        fill(3);
        run_frame(-1);
        check("hstep_298", 0, mdut[299][200], 80);
        check("hstep_299", 0, mdut[300][200], 80);
        check("hstep_297", 0, mdut[298][200], 0);
        check("hstep_300", 0, mdut[301][200], 0);

        // Random image, interrupted by a mid-stream reset, then rerun to completion
        reset_on();
        fill(4);
        run_frame(300);
        rst_n = 1'b1;
        #1;
        check("midrst_valid", 0, valid, 0);
        check("midrst_cnt", 0, {cnt_row, cnt_col}, 0);
        check("midrst_block0", 0, block_out_0, 0);
        check("midrst_block3", 0, block_out_3, 0);
        repeat (2) @(negedge clk);
        run_frame(-1);
        check("border_row_m1", 0, mdut[0][300], 0);
        check("border_row_0", 0, mdut[1][300], 0);
        check("border_col_636", 0, mdut[201][636], 0);
        check("border_col_635", 0, mdut[201][635], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
